// File: rtl/cp0_unit.sv
// Coprocessor 0 for the 5-stage MIPS pipeline: SR/Cause/EPC state, the exception/interrupt
// request decision made in the M stage, mfc0 read data and the eret return target.
module cp0_unit #(
    parameter logic [4:0]  EXC_INT = 5'd0,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        EXLClr,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut,
    output logic [31:0] HandlerPC
);
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;

    // The EXL bit is the state of the two-state machine.
    typedef enum logic {ST_NORMAL = 1'b0, ST_HANDLER = 1'b1} state_t;

    state_t      r_state;
    logic [5:0]  r_im;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_exl;
    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_exl     = (r_state == ST_HANDLER);
    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~w_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~w_exl;
    assign Req       = w_int_req | w_exc_req;

    assign w_sr    = {16'h0000, r_im, 8'h00, w_exl, r_ie};
    assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exccode, 2'b00};

    assign EPCOut    = r_epc;
    assign HandlerPC = HANDLER;

    always_comb begin
        DOut = 32'h0000_0000;
        case (A1)
            REG_SR:    DOut = w_sr;
            REG_CAUSE: DOut = w_cause;
            REG_EPC:   DOut = r_epc;
            default:   DOut = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_NORMAL;
            r_im      <= 6'h00;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'h00;
            r_exccode <= 5'd0;
            r_epc     <= 32'h0000_0000;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                // Taking the request squashes any mtc0/eret in the same instruction slot.
                r_state   <= ST_HANDLER;
                r_exccode <= w_int_req ? EXC_INT : ExcCodeIn;
                r_bd      <= BDIn;
                r_epc     <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (WE && (A2 == REG_SR)) begin
                    r_im    <= DIn[15:10];
                    r_ie    <= DIn[0];
                    r_state <= DIn[1] ? ST_HANDLER : ST_NORMAL;
                end
                if (WE && (A2 == REG_EPC)) begin
                    r_epc <= DIn;
                end
                // Placed last so eret beats a concurrent SR write for the EXL bit.
                if (EXLClr) begin
                    r_state <= ST_NORMAL;
                end
            end
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit; expected values are hand-computed from the register layout.
module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE, EXLClr;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut, DOut, HandlerPC;

    int n_checks = 0;
    int n_errors = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .EXLClr(EXLClr), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .Req(Req), .EPCOut(EPCOut), .DOut(DOut), .HandlerPC(HandlerPC)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            $display("ok   %s: %h", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] num, input logic [31:0] expected);
        A1 = num;
        #1;
        check(tag, DOut, expected);
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0; EXLClr = 1'b0;
        VPC = 32'h0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'h3f;

        // Reset held two cycles with all interrupt lines high.
        tick(); tick();
        check("rst_req", {31'h0, Req}, 32'h0);
        check("rst_epcout", EPCOut, 32'h0);
        check("handler_pc", HandlerPC, 32'h0000_4180);
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);

        // mtc0 SR with all ones: only IM/EXL/IE stick, leaving EXL=1.
        HWInt = 6'h00; reset = 1'b0;
        WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0;
        rd("sr_write_mask", 5'd12, 32'h0000_FC03);
        HWInt = 6'h01; #1;
        check("int_masked_exl", {31'h0, Req}, 32'h0);

        // Clear EXL via mtc0; interrupt now requested.
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        WE = 1'b0; VPC = 32'h0000_2000; BDIn = 1'b0;
        #1;
        check("int_req", {31'h0, Req}, 32'h1);
        rd("cause_ip", 5'd13, 32'h0000_0400);
        tick();
        HWInt = 6'h00;
        check("int_epc", EPCOut, 32'h0000_2000);
        rd("int_sr_exl", 5'd12, 32'h0000_FC03);
        rd("int_cause", 5'd13, 32'h0000_0400);

        // eret
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_FC01);

        // Exception in a branch delay slot with SR=0.
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
        tick();
        WE = 1'b0; ExcCodeIn = 5'd4; VPC = 32'h0000_3008; BDIn = 1'b1;
        #1;
        check("exc_req", {31'h0, Req}, 32'h1);
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("bd_epc", EPCOut, 32'h0000_3004);
        rd("bd_cause", 5'd13, 32'h8000_0010);
        rd("bd_sr", 5'd12, 32'h0000_0002);

        // Exceptions masked while EXL=1.
        ExcCodeIn = 5'd10; #1;
        check("exc_masked", {31'h0, Req}, 32'h0);
        tick();
        ExcCodeIn = 5'd0;
        rd("masked_cause", 5'd13, 32'h8000_0010);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("eret_sr2", 5'd12, 32'h0);

        // Interrupt and exception together, plus a squashed mtc0 EPC.
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        HWInt = 6'h01; ExcCodeIn = 5'd12; A2 = 5'd14; DIn = 32'h0000_1234;
        VPC = 32'h0000_3010; BDIn = 1'b0;
        #1;
        check("both_req", {31'h0, Req}, 32'h1);
        tick();
        HWInt = 6'h00; ExcCodeIn = 5'd0; WE = 1'b0;
        rd("both_cause", 5'd13, 32'h0000_0400);
        check("squash_epc", EPCOut, 32'h0000_3010);
        rd("both_sr", 5'd12, 32'h0000_0403);

        // Reset in the middle of the handler.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        check("mid_rst_epc", EPCOut, 32'h0);

        // mtc0 to Cause has no effect; mtc0 to EPC does.
        WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        rd("cause_ro", 5'd13, 32'h0);
        A2 = 5'd14; DIn = 32'h0000_ABCD;
        tick();
        WE = 1'b0;
        check("mtc0_epc", EPCOut, 32'h0000_ABCD);

        // Delay-slot EPC wraps below zero.
        ExcCodeIn = 5'd4; VPC = 32'h0; BDIn = 1'b1;
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("wrap_epc", EPCOut, 32'hFFFF_FFFC);

        // eret wins the EXL bit over a concurrent SR write.
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0003; EXLClr = 1'b1;
        tick();
        WE = 1'b0; EXLClr = 1'b0;
        rd("exlclr_wins", 5'd12, 32'h0000_0001);
        rd("unmapped_read", 5'd15, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
